// File: rtl/demux1to5_buffered.sv
// demux1to5_buffered: 1-to-5 valid/ready dispatcher with one-entry slot per channel; DEMUX1TO5_DROP_COUNT_EN adds a saturating drop counter
module demux1to5_buffered #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [2:0]             i_dest,
  input  logic [DATA_WIDTH-1:0]  i_data,
  output logic                   o_ready,
  output logic [4:0]             o_valid,
  output logic [DATA_WIDTH-1:0]  o_data_0,
  output logic [DATA_WIDTH-1:0]  o_data_1,
  output logic [DATA_WIDTH-1:0]  o_data_2,
  output logic [DATA_WIDTH-1:0]  o_data_3,
  output logic [DATA_WIDTH-1:0]  o_data_4,
  input  logic [4:0]             i_ready,
  output logic [COUNT_WIDTH-1:0] o_drop_count
);
  logic [4:0]            slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0] slot_data_q [5];
  logic [DATA_WIDTH-1:0] slot_data_d [5];
  logic [4:0]            can_accept, load;
  logic [7:0]            ready_by_dest;
  logic                  dest_ok;
  assign dest_ok       = i_dest <= 3'd4;
  assign can_accept    = ~slot_valid_q | i_ready;
  // invalid destinations map to the constant-one upper bits so they never stall
  assign ready_by_dest = {3'b111, can_accept};
  assign o_ready       = ready_by_dest[i_dest];
  assign o_valid       = slot_valid_q;
  assign o_data_0      = slot_data_q[0];
  assign o_data_1      = slot_data_q[1];
  assign o_data_2      = slot_data_q[2];
  assign o_data_3      = slot_data_q[3];
  assign o_data_4      = slot_data_q[4];
  // per-channel refill/drain: a slot may drain and reload in the same cycle
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      load[k]         = i_valid && dest_ok && can_accept[k] && (i_dest == 3'(k));
      slot_valid_d[k] = load[k] | (slot_valid_q[k] & ~i_ready[k]);
      slot_data_d[k]  = load[k] ? i_data : slot_data_q[k];
    end
  end
  // slot registers; reset discards every buffered word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_valid_q <= '0;
      for (int k = 0; k < 5; k++) slot_data_q[k] <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
    end
  end
`ifdef DEMUX1TO5_DROP_COUNT_EN
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  // count accepted invalid-destination words, holding at all-ones
  always_comb drop_count_d = (i_valid && !dest_ok && !(&drop_count_q)) ? drop_count_q + 1'b1 : drop_count_q;
  // drop counter register
  always_ff @(posedge i_clk) drop_count_q <= i_rst ? '0 : drop_count_d;
  assign o_drop_count = drop_count_q;
`else
  assign o_drop_count = '0;
`endif
endmodule

// File: tb/tb_demux1to5_buffered.sv
// tb_demux1to5_buffered: vector table, corner sequences and random traffic against a queue-based model
module tb_demux1to5_buffered;
  logic        clk = 0;
  logic        rst, vld;
  logic [2:0]  dest;
  logic [63:0] data;
  logic [4:0]  rdy;
  logic        ordy, ordy4;
  logic [4:0]  ovalid, ovalid4;
  logic [63:0] dout [5];
  logic [63:0] dout4 [5];
  logic [15:0] dcnt;
  logic [3:0]  dcnt4;
  int n_checks = 0, n_fail = 0;
  logic [63:0] mq [5][$];
  int mcnt = 0, mcnt4 = 0;

  always #5 clk = ~clk;

  demux1to5_buffered dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_dest(dest), .i_data(data),
    .o_ready(ordy), .o_valid(ovalid),
    .o_data_0(dout[0]), .o_data_1(dout[1]), .o_data_2(dout[2]), .o_data_3(dout[3]), .o_data_4(dout[4]),
    .i_ready(rdy), .o_drop_count(dcnt));

  demux1to5_buffered #(.COUNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_dest(dest), .i_data(data),
    .o_ready(ordy4), .o_valid(ovalid4),
    .o_data_0(dout4[0]), .o_data_1(dout4[1]), .o_data_2(dout4[2]), .o_data_3(dout4[3]), .o_data_4(dout4[4]),
    .i_ready(rdy), .o_drop_count(dcnt4));

  typedef struct {
    logic        v;
    logic [2:0]  d;
    logic [63:0] x;
    logic [4:0]  r;
    logic        er;
    logic [4:0]  ev;
    int          ch;
    logic [63:0] ed;
  } vec_t;
  vec_t tv[$];

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  function automatic logic model_ready();
    if (dest > 3'd4) return 1'b1;
    return mq[dest].size() == 0 || rdy[dest];
  endfunction

  function automatic int exp_cnt(int full);
`ifdef DEMUX1TO5_DROP_COUNT_EN
    return full;
`else
    return 0 * full;
`endif
  endfunction

  function automatic void model_edge(logic acc_rdy);
    if (rst) begin
      for (int k = 0; k < 5; k++) mq[k].delete();
      mcnt = 0;
      mcnt4 = 0;
    end else begin
      for (int k = 0; k < 5; k++) if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
      if (vld && acc_rdy) begin
        if (dest <= 3'd4) mq[dest].push_back(data);
        else begin
          if (mcnt < 65535) mcnt++;
          if (mcnt4 < 15) mcnt4++;
        end
      end
    end
  endfunction

  function automatic void compare_state();
    logic [4:0] ev;
    for (int k = 0; k < 5; k++) ev[k] = mq[k].size() > 0;
    chk("o_valid", 64'(ovalid), 64'(ev));
    chk("o_valid_w4", 64'(ovalid4), 64'(ev));
    for (int k = 0; k < 5; k++)
      if (ev[k]) chk($sformatf("o_data_%0d", k), dout[k], mq[k][0]);
    chk("drop_count", 64'(dcnt), 64'(exp_cnt(mcnt)));
    chk("drop_count_w4", 64'(dcnt4), 64'(exp_cnt(mcnt4)));
  endfunction

  task automatic step();
    logic er;
    #1;
    er = model_ready();
    chk("o_ready", 64'(ordy), 64'(er));
    chk("o_ready_w4", 64'(ordy4), 64'(er));
    @(posedge clk);
    model_edge(er);
    #1;
    compare_state();
  endtask

  task automatic add(logic v, logic [2:0] d, logic [63:0] x, logic [4:0] r,
                     logic er, logic [4:0] ev, int ch, logic [63:0] ed);
    vec_t t;
    t.v = v; t.d = d; t.x = x; t.r = r; t.er = er; t.ev = ev; t.ch = ch; t.ed = ed;
    tv.push_back(t);
  endtask

  initial begin
    add(1, 2, 64'hA5A5, 5'h1F, 1, 5'b00100, 2, 64'hA5A5);
    add(0, 0, 0,        5'h1F, 1, 5'b00000, 7, 0);
    add(1, 0, 64'h11,   5'h00, 1, 5'b00001, 0, 64'h11);
    add(1, 0, 64'h22,   5'h00, 0, 5'b00001, 0, 64'h11);
    add(1, 0, 64'h22,   5'h01, 1, 5'b00001, 0, 64'h22);
    add(0, 0, 0,        5'h1F, 1, 5'b00000, 7, 0);
    add(1, 4, 64'd1,    5'h10, 1, 5'b10000, 4, 64'd1);
    add(1, 4, 64'd2,    5'h10, 1, 5'b10000, 4, 64'd2);
    add(1, 4, 64'd3,    5'h10, 1, 5'b10000, 4, 64'd3);
    add(0, 0, 0,        5'h1F, 1, 5'b00000, 7, 0);
    for (int k = 0; k < 5; k++)
      add(1, 3'(k), 64'(100 + k), 5'h00, 1, 5'((1 << (k + 1)) - 1), k, 64'(100 + k));
    add(1, 6, 64'hDEAD, 5'h00, 1, 5'h1F, 3, 64'd103);
    add(1, 7, 64'hBEEF, 5'h00, 1, 5'h1F, 0, 64'd100);

    rst = 1; vld = 0; dest = 0; data = 0; rdy = 5'h1F;
    step();
    for (int k = 0; k < 5; k++) chk($sformatf("reset_data_%0d", k), dout[k], 64'd0);
    rst = 0;

    foreach (tv[i]) begin
      vld = tv[i].v; dest = tv[i].d; data = tv[i].x; rdy = tv[i].r;
      #1;
      chk($sformatf("vec%0d_o_ready", i), 64'(ordy), 64'(tv[i].er));
      step();
      chk($sformatf("vec%0d_o_valid", i), 64'(ovalid), 64'(tv[i].ev));
      if (tv[i].ch < 5) chk($sformatf("vec%0d_data", i), dout[tv[i].ch], tv[i].ed);
    end
    chk("two_drops", 64'(dcnt), 64'(exp_cnt(2)));

    rst = 1; vld = 1; dest = 1; data = 64'h77; rdy = 5'h00;
    step();
    chk("rst_o_valid", 64'(ovalid), 64'd0);
    chk("rst_drop", 64'(dcnt), 64'd0);
    rst = 0; vld = 0;
    repeat (3) step();
    chk("post_rst_o_valid", 64'(ovalid), 64'd0);

    vld = 1; dest = 5;
    for (int i = 0; i < 20; i++) begin
      data = 64'(i);
      step();
    end
    chk("sat_w4", 64'(dcnt4), 64'(exp_cnt(15)));
    chk("count_20", 64'(dcnt), 64'(exp_cnt(20)));

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      vld  = $urandom_range(0, 3) != 0;
      dest = 3'($urandom_range(0, 7));
      data = {$urandom, $urandom};
      rdy  = 5'($urandom) & 5'($urandom | 32'h15);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
